// File: rtl/cdma_cmd_arb.sv
// Multi-channel DMA command front end: round-robin arbitration onto one engine port,
// an in-order tag FIFO, and routing of engine completions back to the issuing channel.
module cdma_cmd_arb #(
    parameter int N_CH           = 4,
    parameter int ADDR_BITS      = 64,
    parameter int LEN_BITS       = 32,
    parameter int MAX_INFLIGHT   = 16,
    parameter int CH_OUTSTANDING = 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [N_CH-1:0]                  s_valid,
    output logic [N_CH-1:0]                  s_ready,
    input  logic [N_CH*ADDR_BITS-1:0]        s_addr,
    input  logic [N_CH*LEN_BITS-1:0]         s_len,
    output logic [N_CH-1:0]                  s_done,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [ADDR_BITS-1:0]             m_addr,
    output logic [LEN_BITS-1:0]              m_len,
    input  logic                             m_done,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                             err_unexp
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int OW = $clog2(CH_OUTSTANDING + 1);
    localparam logic [IW-1:0] ONE_I = IW'(1'b1);
    localparam logic [PW-1:0] ONE_P = PW'(1'b1);
    localparam logic [OW-1:0] ONE_O = OW'(1'b1);

    logic [CW-1:0]        rr_ptr_r;
    logic [OW-1:0]        cnt_r [N_CH];
    logic [CW-1:0]        fifo_ch_r [MAX_INFLIGHT];
    logic                 fifo_loc_r [MAX_INFLIGHT];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [IW-1:0]        count_r;
    logic [IW-1:0]        nl_cnt_r;
    logic [IW-1:0]        pend_r;
    logic                 m_valid_r;
    logic [ADDR_BITS-1:0] m_addr_r;
    logic [LEN_BITS-1:0]  m_len_r;
    logic [N_CH-1:0]      s_done_r;
    logic                 err_r;

    logic                 out_free_s;
    logic                 full_s;
    logic [N_CH-1:0]      elig_s;
    logic [N_CH-1:0]      len_zero_s;
    logic [ADDR_BITS-1:0] addr_a_s [N_CH];
    logic [LEN_BITS-1:0]  len_a_s [N_CH];
    logic                 grant_s;
    logic [CW-1:0]        grant_ch_s;
    logic [CW-1:0]        idx_s;
    logic [CW-1:0]        rr_next_s;
    logic [ADDR_BITS-1:0] grant_addr_s;
    logic [LEN_BITS-1:0]  grant_len_s;
    logic                 grant_local_s;
    logic [CW-1:0]        head_ch_s;
    logic                 head_loc_s;
    logic                 err_hit_s;
    logic [IW-1:0]        eff_s;
    logic                 retire_s;
    logic                 retire_nl_s;
    logic [N_CH-1:0]      done_vec_s;
    logic [N_CH-1:0]      ready_vec_s;

    // Unpack channel buses and decide which channels may be granted this cycle.
    always_comb begin
        out_free_s = !m_valid_r || m_ready;
        full_s     = (count_r == IW'(MAX_INFLIGHT));
        for (int i = 0; i < N_CH; i++) begin
            addr_a_s[i]   = s_addr[i*ADDR_BITS +: ADDR_BITS];
            len_a_s[i]    = s_len[i*LEN_BITS +: LEN_BITS];
            len_zero_s[i] = (len_a_s[i] == {LEN_BITS{1'b0}});
            elig_s[i]     = s_valid[i] && (cnt_r[i] < OW'(CH_OUTSTANDING)) && !full_s
                            && (len_zero_s[i] || out_free_s);
        end
    end

    // Round-robin pick: first eligible channel at or after rr_ptr.
    always_comb begin
        grant_s    = 1'b0;
        grant_ch_s = {CW{1'b0}};
        idx_s      = {CW{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            idx_s      = CW'((int'(rr_ptr_r) + k) % N_CH);
            grant_ch_s = (!grant_s && elig_s[idx_s]) ? idx_s : grant_ch_s;
            grant_s    = grant_s || elig_s[idx_s];
        end
        rr_next_s     = CW'((int'(grant_ch_s) + 1) % N_CH);
        grant_addr_s  = addr_a_s[grant_ch_s];
        grant_len_s   = len_a_s[grant_ch_s];
        grant_local_s = len_zero_s[grant_ch_s];
    end

    // Head-of-FIFO retire decision; stray completions are flagged and dropped.
    always_comb begin
        head_ch_s   = fifo_ch_r[rd_ptr_r];
        head_loc_s  = fifo_loc_r[rd_ptr_r];
        err_hit_s   = m_done && (nl_cnt_r == pend_r);
        eff_s       = pend_r + {{(IW-1){1'b0}}, (m_done && !err_hit_s)};
        retire_s    = (count_r != {IW{1'b0}}) && (head_loc_s || (eff_s != {IW{1'b0}}));
        retire_nl_s = retire_s && !head_loc_s;
        for (int i = 0; i < N_CH; i++) begin
            done_vec_s[i]  = retire_s && (head_ch_s == CW'(i));
            ready_vec_s[i] = grant_s && (grant_ch_s == CW'(i));
        end
    end

    // Control state: pointers, occupancy, per-channel counters, output register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr_r  <= {CW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {IW{1'b0}};
            nl_cnt_r  <= {IW{1'b0}};
            pend_r    <= {IW{1'b0}};
            m_valid_r <= 1'b0;
            m_addr_r  <= {ADDR_BITS{1'b0}};
            m_len_r   <= {LEN_BITS{1'b0}};
            s_done_r  <= {N_CH{1'b0}};
            err_r     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= {OW{1'b0}};
            end
        end else begin
            if (grant_s) begin
                rr_ptr_r <= rr_next_s;
                wr_ptr_r <= wr_ptr_r + ONE_P;
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_P;
            end
            case ({grant_s, retire_s})
                2'b10:   count_r <= count_r + ONE_I;
                2'b01:   count_r <= count_r - ONE_I;
                default: count_r <= count_r;
            endcase
            case ({grant_s && !grant_local_s, retire_nl_s})
                2'b10:   nl_cnt_r <= nl_cnt_r + ONE_I;
                2'b01:   nl_cnt_r <= nl_cnt_r - ONE_I;
                default: nl_cnt_r <= nl_cnt_r;
            endcase
            pend_r <= retire_nl_s ? (eff_s - ONE_I) : eff_s;
            for (int i = 0; i < N_CH; i++) begin
                case ({ready_vec_s[i], done_vec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + ONE_O;
                    2'b01:   cnt_r[i] <= cnt_r[i] - ONE_O;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
            // Loading only on a nonzero grant keeps m_addr/m_len stable under backpressure.
            if (grant_s && !grant_local_s) begin
                m_valid_r <= 1'b1;
                m_addr_r  <= grant_addr_s;
                m_len_r   <= grant_len_s;
            end else if (out_free_s) begin
                m_valid_r <= 1'b0;
            end
            s_done_r <= done_vec_s;
            err_r    <= err_r | err_hit_s;
        end
    end

    // Tag storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge aclk) begin
        if (grant_s) begin
            fifo_ch_r[wr_ptr_r]  <= grant_ch_s;
            fifo_loc_r[wr_ptr_r] <= grant_local_s;
        end
    end

    assign s_ready   = ready_vec_s;
    assign s_done    = s_done_r;
    assign m_valid   = m_valid_r;
    assign m_addr    = m_addr_r;
    assign m_len     = m_len_r;
    assign inflight  = count_r;
    assign err_unexp = err_r;

endmodule

// File: doc/cdma_cmd_arb.md
Name: cdma_cmd_arb

Overview:
Multi-channel command front end for one direction (RD or WR) of the aligned CDMA. It accepts DMA commands from N_CH independent channels and arbitrates them round-robin onto a single downstream DMA engine control port. It tracks every command in an in-order tag FIFO and routes each engine completion pulse back to the channel that issued it. Two instances (one RD, one WR) replace the fixed single-queue front end of the CDMA top level. Zero-length commands are completed locally and never reach the engine.

Parameters:
N_CH, 4, number of command channels (1..16)
ADDR_BITS, 64, address width
LEN_BITS, 32, transfer length width (bytes)
MAX_INFLIGHT, 16, tag FIFO depth; power of two, >=2
CH_OUTSTANDING, 8, max commands per channel issued but not yet done (1..MAX_INFLIGHT)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_valid  in  N_CH  per-channel command valid
s_ready  out  N_CH  per-channel command accept
s_addr  in  N_CH*ADDR_BITS  per-channel address, channel i at [i*ADDR_BITS +: ADDR_BITS]
s_len  in  N_CH*LEN_BITS  per-channel length, channel i at [i*LEN_BITS +: LEN_BITS]
s_done  out  N_CH  per-channel completion pulse
m_valid  out  1  engine command valid
m_ready  in  1  engine command accept
m_addr  out  ADDR_BITS  engine command address
m_len  out  LEN_BITS  engine command length
m_done  in  1  engine completion pulse; one per accepted command, in issue order
inflight  out  clog2(MAX_INFLIGHT+1)  tag FIFO occupancy
err_unexp  out  1  sticky: m_done received with no engine command outstanding

Behaviour:
- Reset (aresetn=0 at a posedge): m_valid=0, s_done=0, err_unexp=0, inflight=0. Tag FIFO, per-channel counters, pending-done counter and RR pointer are cleared. Contents of m_addr/m_len are don't-care. Reset mid-operation discards all in-flight tracking; later m_done pulses set err_unexp.
- Eligibility of channel i: s_valid[i] & cnt[i]<CH_OUTSTANDING & FIFO not full & (s_len[i]==0 | out_free).
  - out_free = !m_valid | m_ready.
- Grant:
  - At most one channel per cycle, chosen round-robin starting at rr_ptr.
  - s_ready[i] is 1 only for the granted channel (combinational, may depend on s_valid).
  - On a grant, rr_ptr <= granted+1 (mod N_CH).
  - If no channel is eligible, rr_ptr is unchanged.
- Output register:
  - On a grant with nonzero len, m_valid<=1 and m_addr/m_len are loaded on the next edge (grant at T -> m_valid at T+1).
  - If out_free and there is no nonzero-length grant, m_valid<=0.
  - m_addr/m_len are held stable while m_valid & !m_ready.
- Tag FIFO:
  - Every grant pushes {ch, local}, where local = (len==0).
  - cnt[granted] increments on a grant and decrements on retire of that channel. Simultaneous increment and decrement leave it unchanged.
- pend counter (width clog2(MAX_INFLIGHT+1)):
  - Counts m_done pulses not yet retired.
  - eff = pend + m_done.
- Retire (at most one per cycle, FIFO non-empty):
  - If the head entry is local, it retires unconditionally.
  - Else it retires if eff>0.
  - pend <= eff - (nonlocal retire ? 1 : 0).
- err_unexp:
  - Sets when m_done=1 and the number of nonlocal FIFO entries equals pend (the engine has no command outstanding).
  - In that case the pulse is dropped and pend is not incremented.
- s_done: registered one-hot pulse on the retired channel at the cycle after retire. Completion order per channel equals acceptance order.
- Latencies:
  - m_done at T with a nonlocal head gives s_done at T+1.
  - A local command granted at T (FIFO otherwise empty) gives s_done at T+2.
- Full FIFO: no grants. Retire and push in the same cycle are allowed; occupancy stays unchanged.
- inflight reports FIFO occupancy, registered.

Test Plan:
- Single-channel command: ch0 addr=0x1000 len=256, m_ready=1 -> m_valid at T+1 with m_addr=0x1000, m_len=256. Pulse m_done 5 cycles later -> s_done=4'b0001 exactly one cycle later; inflight returns 0.
- Round-robin fairness: all 4 channels hold s_valid with lens 64, m_ready=1 -> grant order 0,1,2,3,0,1,... Eight m_done pulses -> s_done order 0,1,2,3,0,1,2,3.
- Backpressure: m_ready=0 for 10 cycles with ch1 and ch2 valid -> m_valid=1 and m_addr held constant. Only one further grant (0) until m_ready=1; then ch2 is issued next cycle.
- Zero-length command: ch3 len=0 queued behind ch0 len=128 -> ch3 never appears on m_. s_done[3] fires only after s_done[0], which follows m_done.
- Limits: CH_OUTSTANDING=2, ch0 issues 3 commands with no m_done -> third waits with s_ready[0]=0. Fill MAX_INFLIGHT=16 across channels -> all s_ready=0 and inflight=16. One m_done -> one new grant allowed.
- Error and reset: m_done after reset with an empty FIFO -> err_unexp=1 and stays 1. Assert aresetn=0 mid-traffic -> m_valid=0, inflight=0 and err_unexp=0 next cycle.
